if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_pkg.sv | 24 ++
 rtl/inst_mem.sv | 30 +++
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_pkg;

    localparam int          IMEM_DEPTH = 64;
    localparam int          IMEM_AW    = 6;
    localparam logic [31:0] PC_RESET   = 32'h0;
    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam int          PERF_CNT_W = 16;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        vld;
    } ifid_t;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/inst_mem.sv
// Instruction ROM, 64 x 32, asynchronous read, default image filled with NOP_INSTR.
// Latency: combinational (0 cycles) from address to data.
// Backpressure: none; always answers the presented address.
module inst_mem
    import if_pkg::*;
#(
    parameter bit    INIT_EN   = 1'b1,
    parameter string INIT_FILE = "inst_mem.hex"
) (
    input  logic [IMEM_AW-1:0] i_addr,
    output logic [31:0]        o_dat
);

    logic [31:0] r_mem [IMEM_DEPTH];

    // Program image is set once; reset never touches the ROM contents.
    // INIT_EN lets an environment that supplies the image itself skip the default fill.
    generate
        if (INIT_EN) begin : g_init
            initial begin
                for (int i = 0; i < IMEM_DEPTH; i++) begin
                    r_mem[i] = NOP_INSTR;
                end
            end
        end
    endgenerate

    assign o_dat = r_mem[i_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, instruction ROM and IF/ID register (optional perf counters: IF_PERF_CNT_EN).
// Latency: word at PC appears on instruction 1 cycle later; branch target 2 edges after branch_taken.
// Backpressure: freeze holds PC and IF/ID; branch_taken overrides freeze and inserts one bubble.
module if_stage
    import if_pkg::*;
#(
    parameter bit    IMEM_INIT_EN   = 1'b1,
    parameter string IMEM_INIT_FILE = "inst_mem.hex"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_addr,
    output logic [31:0]           PC_out,
    output logic [31:0]           instruction,
    output logic                  valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] fetch_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    logic [31:0] r_pc;
    ifid_t       r_ifid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_pc;
    logic [31:0] w_imem_dat;
    logic        w_unused_addr_bits;

    assign w_pc_plus4  = r_pc + 32'd4;
    // Low address bits are dropped so the PC can never become misaligned
    assign w_branch_pc = {branch_addr[31:2], 2'b00};
    assign w_unused_addr_bits = ^branch_addr[1:0];

    // PC[7:2] indexes the ROM; higher PC bits alias every 256 bytes
    inst_mem #(
        .INIT_EN   (IMEM_INIT_EN),
        .INIT_FILE (IMEM_INIT_FILE)
    ) u_imem (
        .i_addr (r_pc[IMEM_AW+1:2]),
        .o_dat  (w_imem_dat)
    );

    // PC and IF/ID update: reset > branch redirect > freeze hold > advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc            <= PC_RESET;
            r_ifid.pc_plus4 <= 32'h0;
            r_ifid.instr    <= NOP_INSTR;
            r_ifid.vld      <= 1'b0;
        end else if (branch_taken) begin
            r_pc            <= w_branch_pc;
            r_ifid.pc_plus4 <= 32'h0;
            r_ifid.instr    <= NOP_INSTR;
            r_ifid.vld      <= 1'b0;
        end else if (!freeze) begin
            r_pc            <= w_pc_plus4;
            r_ifid.pc_plus4 <= w_pc_plus4;
            r_ifid.instr    <= w_imem_dat;
            r_ifid.vld      <= 1'b1;
        end
    end

    assign PC_out      = r_ifid.pc_plus4;
    assign instruction = r_ifid.instr;
    assign valid       = r_ifid.vld;

`ifdef IF_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] r_fetch_cnt;
    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_flush_cnt;

    // Saturating event counters, classified with the same priority as the PC update
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (branch_taken) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
        end else if (freeze) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end else begin
            r_fetch_cnt <= sat_inc(r_fetch_cnt);
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a reference model.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: exercises freeze and branch_taken, including both together.
module tb_if_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] PC_out;
    logic [31:0] instruction;
    logic        valid;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: PC as a byte address, ROM as a word array
    logic [31:0] m_mem [64];
    logic [31:0] m_pc, m_instr, m_pc_out;
    logic        m_valid;
    int          m_fetch, m_stall, m_flush;

    if_stage #(.IMEM_INIT_EN(1'b0)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .PC_out       (PC_out),
        .instruction  (instruction),
        .valid        (valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model by the rules, and wait until just after the edge
    task automatic step(input logic r_n, input logic f, input logic b, input logic [31:0] a);
        rst = r_n; freeze = f; branch_taken = b; branch_addr = a;
        if (!r_n) begin
            m_pc = 0; m_instr = 0; m_pc_out = 0; m_valid = 0;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (b) begin
            m_pc = (a / 4) * 4;
            m_instr = 0; m_pc_out = 0; m_valid = 0;
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        end else if (f) begin
            m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        end else begin
            m_instr  = m_mem[(m_pc % 256) / 4];
            m_pc     = m_pc + 4;
            m_pc_out = m_pc;
            m_valid  = 1;
            m_fetch  = (m_fetch < 65535) ? m_fetch + 1 : 65535;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        // Reset must win over freeze and branch_taken
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        n_checks++;
        if (instruction !== 32'h0 || PC_out !== 32'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got instr=%h pc_out=%h valid=%b, expected 0/0/0", instruction, PC_out, valid);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (fetch_cnt !== 16'h0 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counters got %h/%h/%h, expected 0/0/0", fetch_cnt, stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++;
            if (instruction !== 32'hE000_0000 + 32'(k) || PC_out !== 32'(4 * (k + 1)) || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq[%0d] got instr=%h pc_out=%h valid=%b, expected %h/%h/1",
                         k, instruction, PC_out, valid, 32'hE000_0000 + 32'(k), 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (instruction !== 32'hE000_0002 || PC_out !== 32'd12 || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d] got instr=%h pc_out=%h valid=%b, expected e0000002/0000000c/1",
                         k, instruction, PC_out, valid);
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_0003 || PC_out !== 32'd16) begin
            n_fail++;
            $display("FAIL freeze_release got instr=%h pc_out=%h, expected e0000003/00000010", instruction, PC_out);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_cnt got %0d, expected 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_branch();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0043);
        n_checks++;
        if (valid !== 1'b0 || instruction !== 32'h0 || PC_out !== 32'h0) begin
            n_fail++;
            $display("FAIL branch_bubble got instr=%h pc_out=%h valid=%b, expected 0/0/0", instruction, PC_out, valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_0010 || PC_out !== 32'h44 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_target got instr=%h pc_out=%h valid=%b, expected e0000010/00000044/1",
                     instruction, PC_out, valid);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (flush_cnt !== 16'd1 || fetch_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL branch_counters got flush=%0d fetch=%0d, expected 1/2", flush_cnt, fetch_cnt);
        end
`endif
    endtask

    task automatic test_alias();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h0000_00FC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_003F || PC_out !== 32'h100) begin
            n_fail++;
            $display("FAIL alias_last got instr=%h pc_out=%h, expected e000003f/00000100", instruction, PC_out);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_0000 || PC_out !== 32'h104) begin
            n_fail++;
            $display("FAIL alias_wrap got instr=%h pc_out=%h, expected e0000000/00000104", instruction, PC_out);
        end
        // PC wraps modulo 2^32 from the last word address
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_0000 || PC_out !== 32'h4) begin
            n_fail++;
            $display("FAIL pc_wrap got instr=%h pc_out=%h, expected e0000000/00000004", instruction, PC_out);
        end
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'h0 || PC_out !== 32'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got instr=%h pc_out=%h valid=%b, expected 0/0/0", instruction, PC_out, valid);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (fetch_cnt !== 16'h0 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_counters got %h/%h/%h, expected 0/0/0", fetch_cnt, stall_cnt, flush_cnt);
        end
`endif
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_0000 || PC_out !== 32'h4 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_restart got instr=%h pc_out=%h valid=%b, expected e0000000/00000004/1",
                     instruction, PC_out, valid);
        end
    endtask

    task automatic test_branch_hold();
        logic [31:0] a;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            a = $urandom;
            step(1'b1, 1'(k % 2), 1'b1, a);
            n_checks++;
            if (valid !== 1'b0 || instruction !== 32'h0) begin
                n_fail++;
                $display("FAIL branch_hold[%0d] got valid=%b instr=%h, expected 0/0", k, valid, instruction);
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (instruction !== 32'hE000_0000 + 32'((a % 256) / 4) || PC_out !== (a / 4) * 4 + 4) begin
            n_fail++;
            $display("FAIL branch_hold_target got instr=%h pc_out=%h, expected %h/%h",
                     instruction, PC_out, 32'hE000_0000 + 32'((a % 256) / 4), (a / 4) * 4 + 4);
        end
    endtask

    task automatic test_random();
        logic r_n, f, b;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r_n = ($urandom_range(99) >= 3);
            f   = ($urandom_range(99) < 30);
            b   = ($urandom_range(99) < 12);
            step(r_n, f, b, $urandom);
            n_checks++;
            if (instruction !== m_instr || PC_out !== m_pc_out || valid !== m_valid) begin
                n_fail++;
                $display("FAIL random[%0d] got instr=%h pc_out=%h valid=%b, expected %h/%h/%b",
                         k, instruction, PC_out, valid, m_instr, m_pc_out, m_valid);
            end
`ifdef IF_PERF_CNT_EN
            n_checks++;
            if (fetch_cnt !== 16'(m_fetch) || stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                n_fail++;
                $display("FAIL random_cnt[%0d] got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         k, fetch_cnt, stall_cnt, flush_cnt, m_fetch, m_stall, m_flush);
            end
`endif
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_saturation();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 65535; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_reach_max got %h, expected ffff", stall_cnt);
        end
        for (int k = 65535; k < 70000; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (stall_cnt !== 16'hFFFF || instruction !== 32'hE000_0000 || PC_out !== 32'h4) begin
            n_fail++;
            $display("FAIL stall_saturate got cnt=%h instr=%h pc_out=%h, expected ffff/e0000000/00000004",
                     stall_cnt, instruction, PC_out);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = 32'hE000_0000 + 32'(i);
            u_dut.u_imem.r_mem[i] = 32'hE000_0000 + 32'(i);
        end
        test_reset();
        test_sequential();
        test_freeze();
        test_branch();
        test_alias();
        test_reset_mid_freeze();
        test_branch_hold();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
